// File: rtl/mux_scan_n1.sv
// N-channel, W-bit mux with registered output: manual select or autonomous scan with per-channel dwell.
// One cycle from X/sel/mode to Y/ch; en low freezes position and drops y_valid.
module mux_scan_n1 #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   X,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                en,
  output logic [W-1:0]        Y,
  output logic [SEL_W-1:0]    ch,
  output logic                y_valid,
  output logic                wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] scan_ch, scan_ch_nx, cur_ch;
  logic [DW_W-1:0]  dwell, dwell_nx, cur_dw;
  logic [W-1:0]     y_nx, sel_dat, scan_dat;
  logic [SEL_W-1:0] ch_nx;
  logic             vld_nx, wrap_nx, sel_hit;

  // A scan entered at this edge starts from channel 0, dwell 0 regardless of stale counters.
  assign cur_ch = (state == SCAN) ? scan_ch : '0;
  assign cur_dw = (state == SCAN) ? dwell   : '0;

  always_comb begin
    sel_dat  = '0;
    sel_hit  = 1'b0;
    scan_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_dat = X[k*W +: W];
        sel_hit = 1'b1;
      end
      if (cur_ch == SEL_W'(k)) scan_dat = X[k*W +: W];
    end
  end

  always_comb begin
    state_nx   = mode ? SCAN : MANUAL;
    scan_ch_nx = cur_ch;
    dwell_nx   = cur_dw;
    y_nx       = Y;
    ch_nx      = ch;
    vld_nx     = 1'b0;
    wrap_nx    = 1'b0;
    if (!mode) begin
      scan_ch_nx = '0;
      dwell_nx   = '0;
    end
    if (en) begin
      if (mode) begin
        y_nx   = scan_dat;
        ch_nx  = cur_ch;
        vld_nx = 1'b1;
        if (cur_dw == LAST_DW) begin
          dwell_nx   = '0;
          scan_ch_nx = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
          wrap_nx    = (cur_ch == LAST_CH);
        end else begin
          dwell_nx = cur_dw + DW_W'(1);
        end
      end else begin
        // Out-of-range selects present zero and flag the sample invalid.
        y_nx   = sel_hit ? sel_dat : '0;
        ch_nx  = sel;
        vld_nx = sel_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MANUAL;
      scan_ch <= '0;
      dwell   <= '0;
      Y       <= '0;
      ch      <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      scan_ch <= scan_ch_nx;
      dwell   <= dwell_nx;
      Y       <= y_nx;
      ch      <= ch_nx;
      y_valid <= vld_nx;
      wrap    <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_n1.sv
// Bench for mux_scan_n1: three instances (4x1 dwell 4, 4x8 dwell 3, 5x4 dwell 2) sharing clock and reset.
module tb_mux_scan_n1;

  logic clk, rst_n;

  logic [3:0]  xa;  logic [1:0] sela; logic modea, ena;
  logic [0:0]  ya;  logic [1:0] cha;  logic va, wa;
  logic [31:0] xb;  logic [1:0] selb; logic modeb, enb;
  logic [7:0]  yb;  logic [1:0] chb;  logic vb, wb;
  logic [19:0] xc;  logic [2:0] selc; logic modec, enc;
  logic [3:0]  yc;  logic [2:0] chc;  logic vc, wc;

  mux_scan_n1 #(.N_CH(4), .W(1), .SEL_W(2), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .X(xa), .sel(sela), .mode(modea), .en(ena),
    .Y(ya), .ch(cha), .y_valid(va), .wrap(wa));
  mux_scan_n1 #(.N_CH(4), .W(8), .SEL_W(2), .DWELL(3)) u_b (
    .clk(clk), .rst_n(rst_n), .X(xb), .sel(selb), .mode(modeb), .en(enb),
    .Y(yb), .ch(chb), .y_valid(vb), .wrap(wb));
  mux_scan_n1 #(.N_CH(5), .W(4), .SEL_W(3), .DWELL(2)) u_c (
    .clk(clk), .rst_n(rst_n), .X(xc), .sel(selc), .mode(modec), .en(enc),
    .Y(yc), .ch(chc), .y_valid(vc), .wrap(wc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          dut;
    logic [31:0] y;
    logic [7:0]  ch;
    logic        vld;
    logic        wrap;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0] x;
    logic [1:0] sel;
    logic       y;
  } mvec_t;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] y;
    logic       vld;
  } cvec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input exp_t e);
    logic [31:0] ay;
    logic [7:0]  ach;
    logic        av, aw;
    case (e.dut)
      0:       begin ay = 32'(ya); ach = 8'(cha); av = va; aw = wa; end
      1:       begin ay = 32'(yb); ach = 8'(chb); av = vb; aw = wb; end
      default: begin ay = 32'(yc); ach = 8'(chc); av = vc; aw = wc; end
    endcase
    n_chk++;
    if (ay !== e.y || ach !== e.ch || av !== e.vld || aw !== e.wrap) begin
      n_fail++;
      $display("FAIL %s: got Y=%h ch=%0d y_valid=%b wrap=%b, expected Y=%h ch=%0d y_valid=%b wrap=%b",
               e.name, ay, ach, av, aw, e.y, e.ch, e.vld, e.wrap);
    end
  endtask

  task automatic push(input int d, input logic [31:0] y, input logic [7:0] c,
                      input logic v, input logic w, input string n);
    exp_t e;
    e.dut = d; e.y = y; e.ch = c; e.vld = v; e.wrap = w; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_now(input int d, input logic [31:0] y, input logic [7:0] c,
                           input logic v, input logic w, input string n);
    exp_t e;
    e.dut = d; e.y = y; e.ch = c; e.vld = v; e.wrap = w; e.name = n;
    check(e);
  endtask

  // Advance one edge and retire every expectation registered by it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  mvec_t       mv[66];
  cvec_t       cv[6];
  int          seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic [7:0]  bval[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    mv[0] = '{x: 4'b1010, sel: 2'd1, y: 1'b1};
    mv[1] = '{x: 4'b1010, sel: 2'd2, y: 1'b0};
    for (int i = 0; i < 64; i++) begin
      logic [3:0] t;
      mv[i+2].x   = 4'(i >> 2);
      mv[i+2].sel = 2'(i);
      t = mv[i+2].x >> mv[i+2].sel;
      mv[i+2].y = t[0];
    end
    cv[0] = '{sel: 3'd5, y: 4'h0, vld: 1'b0};
    cv[1] = '{sel: 3'd6, y: 4'h0, vld: 1'b0};
    cv[2] = '{sel: 3'd7, y: 4'h0, vld: 1'b0};
    cv[3] = '{sel: 3'd4, y: 4'h5, vld: 1'b1};
    cv[4] = '{sel: 3'd0, y: 4'h1, vld: 1'b1};
    cv[5] = '{sel: 3'd2, y: 4'h3, vld: 1'b1};

    rst_n = 1'b0;
    xa = 4'hF;  sela = 2'd3; modea = 1'b1; ena = 1'b1;
    xb = '1;    selb = 2'd0; modeb = 1'b1; enb = 1'b1;
    xc = '1;    selc = 3'd0; modec = 1'b1; enc = 1'b1;

    // Reset held with all-ones inputs and scan requested
    repeat (2) @(posedge clk);
    #1;
    check_now(0, 32'h0, 8'd0, 1'b0, 1'b0, "reset_a");
    check_now(1, 32'h0, 8'd0, 1'b0, 1'b0, "reset_b");
    check_now(2, 32'h0, 8'd0, 1'b0, 1'b0, "reset_c");
    rst_n = 1'b1;
    modea = 1'b0; modeb = 1'b0; modec = 1'b0;

    // Manual sweep on the 4x1 instance
    for (int i = 0; i < 66; i++) begin
      xa = mv[i].x;
      sela = mv[i].sel;
      push(0, 32'(mv[i].y), 8'(mv[i].sel), 1'b1, 1'b0, "manual_sweep");
      tick();
    end

    // Scan from manual on the 4x8 instance
    xb = 32'h44332211;
    modeb = 1'b1;
    for (int i = 0; i < 13; i++) begin
      push(1, 32'(bval[seq[i]]), 8'(seq[i]), 1'b1, (i == 11), "scan_seq");
      tick();
    end

    // Enable gating at channel 2, second dwell cycle
    modeb = 1'b0; selb = 2'd0;
    push(1, 32'h11, 8'd0, 1'b1, 1'b0, "manual_b");
    tick();
    modeb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(1, 32'(bval[seq[i]]), 8'(seq[i]), 1'b1, 1'b0, "scan_pre_gate");
      tick();
    end
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1, 32'h33, 8'd2, 1'b0, 1'b0, "gated_hold");
      tick();
    end
    enb = 1'b1;
    push(1, 32'h33, 8'd2, 1'b1, 1'b0, "resume_ch2");
    tick();
    for (int i = 0; i < 3; i++) begin
      push(1, 32'h44, 8'd3, 1'b1, (i == 2), "resume_ch3");
      tick();
    end

    // Live tracking of X during dwell, then mode toggle mid-scan at ch 1
    push(1, 32'h11, 8'd0, 1'b1, 1'b0, "live_0");
    tick();
    xb = 32'h443322AA;
    push(1, 32'hAA, 8'd0, 1'b1, 1'b0, "live_1");
    tick();
    xb = 32'h44332211;
    push(1, 32'h11, 8'd0, 1'b1, 1'b0, "live_2");
    tick();
    push(1, 32'h22, 8'd1, 1'b1, 1'b0, "toggle_ch1");
    tick();
    modeb = 1'b0; selb = 2'd3;
    push(1, 32'h44, 8'd3, 1'b1, 1'b0, "toggle_manual3");
    tick();
    selb = 2'd2;
    push(1, 32'h33, 8'd2, 1'b1, 1'b0, "toggle_manual2");
    tick();
    modeb = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(1, 32'(bval[seq[i]]), 8'(seq[i]), 1'b1, 1'b0, "toggle_restart");
      tick();
    end

    // Asynchronous reset mid-scan, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_now(1, 32'h0, 8'd0, 1'b0, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1, 32'(bval[seq[i]]), 8'(seq[i]), 1'b1, 1'b0, "post_reset_scan");
      tick();
    end

    // Mode changes while disabled: leave SCAN, re-enter, counters restart
    enb = 1'b0; modeb = 1'b0;
    push(1, 32'h22, 8'd1, 1'b0, 1'b0, "dis_to_manual");
    tick();
    modeb = 1'b1;
    push(1, 32'h22, 8'd1, 1'b0, 1'b0, "dis_to_scan");
    tick();
    enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1, 32'(bval[seq[i]]), 8'(seq[i]), 1'b1, 1'b0, "dis_restart");
      tick();
    end

    // Out-of-range selects on the 5-channel instance
    modec = 1'b0; enc = 1'b1;
    xc = 20'h54321;
    for (int i = 0; i < 6; i++) begin
      selc = cv[i].sel;
      push(2, 32'(cv[i].y), 8'(cv[i].sel), cv[i].vld, 1'b0, "sel_range");
      tick();
    end
    enc = 1'b0; selc = 3'd1;
    push(2, 32'h3, 8'd2, 1'b0, 1'b0, "manual_hold");
    tick();

    // Scan on 5 channels with dwell 2: wrap on the tenth enabled cycle
    enc = 1'b1; modec = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(2, 32'((i / 2) % 5 + 1), 8'((i / 2) % 5), 1'b1, (i == 9), "scan_c");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
